// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_piso.sv
// Parallel-in serial-out shift register; bit 0 is presented first and load beats shift.
module uart_piso
    import uart_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      shift,
    input  logic [UART_DATA_BITS-1:0] d_in,
    output logic                      d_out
);

    logic [UART_DATA_BITS-1:0] shift_r;

    // Word storage: synchronous clear, then load, then right shift
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r <= {UART_DATA_BITS{1'b0}};
        end else if (load) begin
            shift_r <= d_in;
        end else if (shift) begin
            shift_r <= {1'b0, shift_r[UART_DATA_BITS-1:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

    assign d_out = shift_r[0];

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte interface; tx_en is enable and synchronous reset.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8
) (
    input  logic       tx_clk,
    input  logic       tx_en,
    input  logic [7:0] tx_i_data,
    input  logic       tx_i_data_valid,
    output logic       tx_o,
    output logic       tx_o_ready
);

    localparam int          CNT_W     = (CLKS_PER_BIT > 32'sd1) ? $clog2(CLKS_PER_BIT) : 32'sd1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 32'sd1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 32'sd1);

    tx_state_t        state_r;
    tx_state_t        state_s;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [CNT_W-1:0] baud_cnt_s;
    logic [2:0]       bit_cnt_r;
    logic [2:0]       bit_cnt_s;
    logic             tx_r;
    logic             tx_s;
    logic             ready_r;
    logic             ready_s;
    logic             accept_s;
    logic             baud_done_s;
    logic             load_s;
    logic             shift_s;
    logic             piso_bit_s;

    assign accept_s    = tx_i_data_valid & ready_r;
    assign baud_done_s = (baud_cnt_r == BAUD_LAST);

    uart_piso u_piso (
        .clk   (tx_clk),
        .rst_n (tx_en),
        .load  (load_s),
        .shift (shift_s),
        .d_in  (tx_i_data),
        .d_out (piso_bit_s)
    );

    // Next-state, counter and next-line-level decode
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        tx_s       = tx_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        // tx_s is the level for the coming bit period; the shifter advances as each data bit is taken
        case (state_r)
            IDLE: begin
                baud_cnt_s = {CNT_W{1'b0}};
                bit_cnt_s  = 3'd0;
                if (accept_s) begin
                    state_s = START;
                    load_s  = 1'b1;
                    tx_s    = 1'b0;
                end else begin
                    tx_s = UART_IDLE_LEVEL;
                end
            end
            START: begin
                if (baud_done_s) begin
                    state_s    = DATA;
                    baud_cnt_s = {CNT_W{1'b0}};
                    bit_cnt_s  = 3'd0;
                    tx_s       = piso_bit_s;
                    shift_s    = 1'b1;
                end else begin
                    baud_cnt_s = baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DATA: begin
                if (baud_done_s) begin
                    baud_cnt_s = {CNT_W{1'b0}};
                    if (bit_cnt_r == BIT_LAST) begin
                        state_s = STOP;
                        tx_s    = UART_IDLE_LEVEL;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        tx_s      = piso_bit_s;
                        shift_s   = 1'b1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            STOP: begin
                if (baud_done_s) begin
                    state_s    = IDLE;
                    baud_cnt_s = {CNT_W{1'b0}};
                    tx_s       = UART_IDLE_LEVEL;
                end else begin
                    baud_cnt_s = baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s    = IDLE;
                baud_cnt_s = {CNT_W{1'b0}};
                bit_cnt_s  = 3'd0;
                tx_s       = UART_IDLE_LEVEL;
            end
        endcase
        ready_s = (state_s == IDLE);
    end

    // State, counters and registered outputs; tx_en low clears everything
    always_ff @(posedge tx_clk) begin
        if (!tx_en) begin
            state_r    <= IDLE;
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            tx_r       <= UART_IDLE_LEVEL;
            ready_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            tx_r       <= tx_s;
            ready_r    <= ready_s;
        end
    end

    assign tx_o       = tx_r;
    assign tx_o_ready = ready_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus randomized frames against a frame model.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       en, valid, tx, rdy;
    logic [7:0] data;
    logic       en3, valid3, tx3, rdy3;
    logic [7:0] data3;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(1)) dut (
        .tx_clk(clk), .tx_en(en), .tx_i_data(data), .tx_i_data_valid(valid),
        .tx_o(tx), .tx_o_ready(rdy)
    );

    uart_tx #(.CLKS_PER_BIT(3)) dut3 (
        .tx_clk(clk), .tx_en(en3), .tx_i_data(data3), .tx_i_data_valid(valid3),
        .tx_o(tx3), .tx_o_ready(rdy3)
    );

    // Expected line level for each of the ten bit periods of a frame
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic [9:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records n samples after successive edges; optionally withdraws the word after the accept edge
    task automatic capture(input int n, input bit drop, output logic [31:0] txs, output logic [31:0] rdys);
        txs  = 32'd0;
        rdys = 32'd0;
        for (int k = 0; k < n; k++) begin
            step();
            txs[k]  = tx;
            rdys[k] = rdy;
            if (drop && k == 0) begin
                valid = 1'b0;
                data  = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        en    = 1'b0;
        valid = 1'($urandom);
        data  = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            step();
            checks += 2;
            if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx cycle %0d got=%b exp=1", k, tx); end
            if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready cycle %0d got=%b exp=0", k, rdy); end
        end
        valid = 1'b0;
        en    = 1'b1;
        step();
        checks += 2;
        if (rdy !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", rdy); end
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_release_tx got=%b exp=1", tx); end
    endtask

    task automatic test_fixed_frame(input logic [7:0] d, input string name);
        logic [31:0] txs, rdys;
        data  = d;
        valid = 1'b1;
        capture(11, 1'b1, txs, rdys);
        checks += 3;
        if (txs[9:0] !== frame_of(d)) begin
            errors++; $display("FAIL %s_bits got=%b exp=%b (bit k at position k)", name, txs[9:0], frame_of(d));
        end
        if (rdys[10:0] !== 11'b100_0000_0000) begin
            errors++; $display("FAIL %s_ready got=%b exp=%b", name, rdys[10:0], 11'b100_0000_0000);
        end
        if (txs[10] !== 1'b1) begin errors++; $display("FAIL %s_idle_after got=%b exp=1", name, txs[10]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] txs, rdys;
        logic [20:0] exp_tx;
        txs    = 32'd0;
        rdys   = 32'd0;
        exp_tx = {frame_of(8'hFF), 1'b1, frame_of(8'h00)};
        data   = 8'h00;
        valid  = 1'b1;
        for (int k = 0; k < 21; k++) begin
            step();
            txs[k]  = tx;
            rdys[k] = rdy;
            if (k == 0) data = 8'hFF;
            if (k == 11) valid = 1'b0;
        end
        step();
        checks += 3;
        if (txs[20:0] !== exp_tx) begin errors++; $display("FAIL b2b_bits got=%b exp=%b", txs[20:0], exp_tx); end
        if (rdys[20:0] !== 21'h000400) begin errors++; $display("FAIL b2b_ready got=%b exp=%b", rdys[20:0], 21'h000400); end
        if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_final_ready got=%b exp=1", rdy); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] txs, rdys;
        logic [7:0]  d;
        logic [15:0] exp_tx;
        txs  = 32'd0;
        rdys = 32'd0;
        d    = 8'($urandom);
        if (d == 8'h55) d = 8'hA3;
        exp_tx = {6'b111111, frame_of(d)};
        data   = d;
        valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            txs[k]  = tx;
            rdys[k] = rdy;
            if (k == 0) begin valid = 1'b0; data = 8'($urandom); end
            if (k == 4) begin valid = 1'b1; data = 8'h55; end
            if (k == 5) valid = 1'b0;
        end
        checks += 2;
        if (txs[15:0] !== exp_tx) begin errors++; $display("FAIL busy_bits got=%b exp=%b", txs[15:0], exp_tx); end
        if (rdys[15:0] !== 16'hFC00) begin errors++; $display("FAIL busy_ready got=%b exp=%b", rdys[15:0], 16'hFC00); end
    endtask

    task automatic test_abort();
        logic [31:0] txs, rdys;
        logic [7:0]  d;
        logic [9:0]  f;
        int          bad;
        d = 8'($urandom) & 8'hF7;
        f = frame_of(d);
        data  = d;
        valid = 1'b1;
        capture(5, 1'b1, txs, rdys);
        checks++;
        if (txs[4:0] !== f[4:0]) begin errors++; $display("FAIL abort_prefix got=%b exp=%b", txs[4:0], f[4:0]); end
        en = 1'b0;
        step();
        checks += 2;
        if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx got=%b exp=1", tx); end
        if (rdy !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", rdy); end
        en = 1'b1;
        step();
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL abort_reenable_ready got=%b exp=1", rdy); end
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tx !== 1'b1 || rdy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_no_partial bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_random();
        logic [31:0] txs, rdys;
        logic [7:0]  d;
        int          bad;
        int          waited;
        for (int n = 0; n < 24; n++) begin
            bad = 0;
            valid = 1'b0;
            for (int g = 0; g < $urandom_range(0, 3); g++) begin
                step();
                if (tx !== 1'b1) bad++;
            end
            waited = 0;
            while (rdy !== 1'b1 && waited < 30) begin step(); waited++; end
            checks++;
            if (rdy !== 1'b1 || bad != 0) begin
                errors++; $display("FAIL rand_idle frame %0d ready=%b idle_bad=%0d exp ready=1 idle_bad=0", n, rdy, bad);
            end
            d     = 8'($urandom);
            data  = d;
            valid = 1'b1;
            capture(11, 1'b1, txs, rdys);
            checks += 2;
            if (txs[9:0] !== frame_of(d)) begin
                errors++; $display("FAIL rand_bits frame %0d data=%h got=%b exp=%b", n, d, txs[9:0], frame_of(d));
            end
            if (rdys[10:0] !== 11'b100_0000_0000) begin
                errors++; $display("FAIL rand_ready frame %0d got=%b exp=%b", n, rdys[10:0], 11'b100_0000_0000);
            end
        end
    endtask

    task automatic test_slow_baud();
        logic [31:0] txs, rdys, exp_tx, exp_rdy;
        logic [9:0]  f;
        logic [7:0]  d;
        txs = 32'd0; rdys = 32'd0; exp_tx = 32'd0; exp_rdy = 32'd0;
        en3 = 1'b0;
        valid3 = 1'b0;
        step(); step();
        en3 = 1'b1;
        step();
        checks++;
        if (rdy3 !== 1'b1 || tx3 !== 1'b1) begin errors++; $display("FAIL slow_idle ready=%b tx=%b exp 1 1", rdy3, tx3); end
        d = 8'($urandom);
        f = frame_of(d);
        for (int k = 0; k < 31; k++) begin
            exp_tx[k]  = (k < 30) ? f[k / 3] : 1'b1;
            exp_rdy[k] = (k == 30);
        end
        data3  = d;
        valid3 = 1'b1;
        for (int k = 0; k < 31; k++) begin
            step();
            txs[k]  = tx3;
            rdys[k] = rdy3;
            if (k == 0) begin valid3 = 1'b0; data3 = ~d; end
        end
        checks += 2;
        if (txs[30:0] !== exp_tx[30:0]) begin errors++; $display("FAIL slow_bits data=%h got=%b exp=%b", d, txs[30:0], exp_tx[30:0]); end
        if (rdys[30:0] !== exp_rdy[30:0]) begin errors++; $display("FAIL slow_ready got=%b exp=%b", rdys[30:0], exp_rdy[30:0]); end
    endtask

    initial begin
        en = 1'b0; valid = 1'b0; data = 8'h00;
        en3 = 1'b0; valid3 = 1'b0; data3 = 8'h00;
        test_reset();
        test_fixed_frame(8'hAA, "single");
        test_fixed_frame(8'h19, "second");
        test_back_to_back();
        test_busy_ignore();
        test_abort();
        test_random();
        test_slow_baud();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
